// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: control/status bundle between a scan controller and scan_sequencer.
// skip[15:0] is present only when SCAN_SKIP_EN is defined.
interface scan_sequencer_if;
  logic start;
  logic single;
  logic stop;
  logic hold;
`ifdef SCAN_SKIP_EN
  logic [15:0] skip;
`endif
  logic [3:0] sel;
  logic valid;
  logic wrap;
  logic busy;
  logic done;
`ifdef SCAN_SKIP_EN
  modport master(output start, single, stop, hold, skip, input sel, valid, wrap, busy, done);
  modport slave(input start, single, stop, hold, skip, output sel, valid, wrap, busy, done);
`else
  modport master(output start, single, stop, hold, input sel, valid, wrap, busy, done);
  modport slave(input start, single, stop, hold, output sel, valid, wrap, busy, done);
`endif
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 4-bit decoder index 0..LAST, holding each for DWELL cycles.
// Define SCAN_SKIP_EN to add a per-index skip mask to the interface.
module scan_sequencer #(
  parameter int DWELL = 4,
  parameter int LAST  = 15
) (
  input logic clk,
  input logic rst_n,
  scan_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, FINISH} state_t;
  state_t r_state;
  logic [3:0] r_idx;
  logic [7:0] r_cnt;
  logic r_single, r_valid, r_wrap, r_busy, r_done;
  logic [15:0] w_skip;
  logic [3:0] w_first, w_next;
  logic w_has_first, w_has_next;
`ifdef SCAN_SKIP_EN
  assign w_skip = bus.skip;
`else
  assign w_skip = '0;
`endif
  // descending search leaves the lowest qualifying index in each result
  always_comb begin
    w_first = '0;
    w_next = '0;
    w_has_first = 1'b0;
    w_has_next = 1'b0;
    for (int i = LAST; i >= 0; i--) begin
      if (!w_skip[4'(i)]) begin
        w_first = 4'(i);
        w_has_first = 1'b1;
        if (4'(i) > r_idx) begin
          w_next = 4'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end
  assign bus.sel = {r_idx[0], r_idx[1], r_idx[2], r_idx[3]};
  assign bus.valid = r_valid;
  assign bus.wrap = r_wrap;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_single <= 1'b0;
      r_valid <= 1'b0;
      r_wrap <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start && !bus.stop) begin
          r_single <= bus.single;
          r_cnt <= '0;
          if (w_has_first) begin
            r_state <= RUN;
            r_idx <= w_first;
            r_valid <= 1'b1;
            r_busy <= 1'b1;
          end else begin
            r_state <= FINISH;
            r_done <= 1'b1;
          end
        end
        RUN: if (bus.stop) begin
          r_state <= IDLE;
          r_idx <= '0;
          r_cnt <= '0;
          r_valid <= 1'b0;
          r_busy <= 1'b0;
        end else if (bus.hold) begin
          r_state <= HOLD;
          r_valid <= 1'b0;
        end else if (r_cnt == 8'(DWELL - 1)) begin
          r_cnt <= '0;
          if (w_has_next) r_idx <= w_next;
          else if (r_single) begin
            r_state <= FINISH;
            r_idx <= '0;
            r_valid <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_idx <= w_first;
            r_wrap <= 1'b1;
          end
        end else r_cnt <= r_cnt + 8'd1;
        HOLD: if (bus.stop) begin
          r_state <= IDLE;
          r_idx <= '0;
          r_cnt <= '0;
          r_valid <= 1'b0;
          r_busy <= 1'b0;
        end else if (!bus.hold) begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Clocked index generator that produces the 4-bit code driving the 16-output decoder.
- Steps through indices 0..LAST and holds each one for DWELL cycles.
- Runs as a single pass or continuously, with start/stop/hold control.
- Drives valid, wrap and done status so downstream logic can qualify the decoded one-hot line.

Parameters:
DWELL, 4, cycles each index is held; legal range 1..256.
LAST, 15, final index of a pass; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
start  input  1  begin a scan; only honoured in IDLE.
single  input  1  sampled with start; 1 = one pass then stop, 0 = continuous.
stop  input  1  abort the scan and return to IDLE.
hold  input  1  freeze the scan while high.
sel  output  4  current index. sel[0] is the MSB and sel[3] the LSB, matching the decoder input ordering.
valid  output  1  sel is an active scan index.
wrap  output  1  one-cycle pulse when a continuous scan returns from LAST to 0.
busy  output  1  high in RUN or HOLD.
done  output  1  one-cycle pulse when a single pass completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sel=0, valid=0, wrap=0, busy=0, done=0, dwell counter=0, single latch=0. Applies mid-scan with no completion pulse.
- Internal state: dwell counter is 8 bits and counts 0..DWELL-1. Index register is 4 bits in natural binary; bit-reversed onto the sel port.
- States: IDLE, RUN, HOLD, FINISH.
- IDLE, start=1 and stop=0: next cycle state=RUN, sel=0, valid=1, busy=1, counter=0; single is latched.
  - start with stop in the same cycle: stop wins, remain IDLE.
- RUN, counter advances each cycle. When counter==DWELL-1 and hold=0:
  - counter clears.
  - If index<LAST: index+1.
  - If index==LAST and single latched: go to FINISH.
  - If index==LAST and continuous: index=0, with wrap=1 in the same cycle sel shows 0.
- DWELL=1: index advances every cycle.
- LAST=0, continuous: sel stays 0 and wrap pulses every DWELL cycles.
- RUN, hold=1: next cycle state=HOLD, valid=0. sel and counter are frozen and no advance occurs, even on the terminal dwell cycle.
- HOLD, hold=0: return to RUN, valid=1, counter resumes from its frozen value.
- stop=1 in RUN or HOLD: next cycle state=IDLE, sel=0, valid=0, busy=0, counter=0, no done pulse. stop has priority over hold and over any advance.
- FINISH lasts one cycle: valid=0, busy=0, done=1, sel=0. Then IDLE, with done returning to 0.
  - start asserted during FINISH is ignored.
- start while busy: ignored; single is not re-latched.
- wrap and done are registered pulses, exactly one cycle wide, never both high together.
- Latency:
  - start to first valid sel: 1 cycle.
  - One full pass: (LAST+1)*DWELL cycles of valid, excluding hold cycles.

Optional Feature:
- Macro SCAN_SKIP_EN.
- Defined: adds input port skip[15:0], sampled every cycle.
  - Advance selects the next index above the current one whose skip bit is 0. If none remain up to LAST, the pass ends (FINISH, or wrap to the lowest unskipped index).
  - Start begins at the lowest unskipped index.
  - All indices 0..LAST skipped: start goes directly to FINISH, done=1 with valid never asserted.
  - Skipping costs no extra cycles.
- Undefined: no skip port; every index 0..LAST is visited.

Test Plan:
- Reset with DWELL=4, LAST=15 -> all outputs 0.
  - start=1, single=1 -> sel steps 0,1,..,15, each valid for 4 cycles, 64 valid cycles.
  - Then done=1 for one cycle, busy=0, sel=0.
- DWELL=1, LAST=3, single=0 -> sel 0,1,2,3,0,1.. every cycle; wrap=1 exactly on each sel=0 re-entry.
- hold=1 on the 4th cycle of index 5 (DWELL=4), held 3 cycles -> valid=0 for 3 cycles, sel stays 5, no advance.
  - After release, index 5 is still on its terminal dwell cycle: sel shows 5 for one more valid cycle, then 6.
- stop=1 at sel=9 -> next cycle IDLE, sel=0, valid=0, done=0.
  - start and stop asserted together in IDLE -> stays IDLE.
- rst_n=0 for one cycle at sel=7 mid-scan -> next cycle all outputs 0, state IDLE.
  - A subsequent start restarts at sel=0.
- SCAN_SKIP_EN, skip=16'h00F0, LAST=15, DWELL=2, single=1 -> sel visits 0-3 then 8-15 (indices 4-7 never appear), 24 valid cycles then done.
  - skip=16'hFFFF -> done pulse 1 cycle after start, valid stays 0.
